// File: rtl/shared_mul_rr_if.sv
// Request/result bundle for shared_mul_rr: per-channel operand handshakes plus
// one tagged result stream. The multiplier side uses the slave modport.
interface shared_mul_rr_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]       req_valid_in;
    logic [N_CH-1:0]       req_ready_out;
    logic [N_CH*WIDTH-1:0] a_in;
    logic [N_CH*WIDTH-1:0] b_in;
    logic                  res_valid_out;
    logic                  res_ready_in;
    logic [2*WIDTH-1:0]    res_out;
    logic [CH_W-1:0]       res_ch_out;

    modport slave (
        input  req_valid_in, a_in, b_in, res_ready_in,
        output req_ready_out, res_valid_out, res_out, res_ch_out
    );

    modport master (
        output req_valid_in, a_in, b_in, res_ready_in,
        input  req_ready_out, res_valid_out, res_out, res_ch_out
    );
endinterface

// File: rtl/shared_mul_rr.sv
// One pipelined multiplier shared by N_CH requesters with round-robin grant.
// Define SHARED_MUL_SIGNED_EN for two's-complement operands and product.
module shared_mul_rr #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int PIPE  = 2
) (
    input logic           clk_in,
    input logic           rst_n_in,
    shared_mul_rr_if.slave bus
);
    localparam int CH_W = $clog2(N_CH);

    logic [CH_W-1:0]    ptr;
    logic [N_CH-1:0]    grant;
    logic [CH_W-1:0]    grant_idx;
    logic               found;
    logic               adv;
    logic               xfer;
    int unsigned        scan_idx;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;

    logic               vld_q  [PIPE];
    logic [2*WIDTH-1:0] prod_q [PIPE];
    logic [CH_W-1:0]    ch_q   [PIPE];

    assign adv = !vld_q[PIPE-1] || bus.res_ready_in;

    // First valid channel at or above ptr, wrapping.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan_idx  = 0;
        for (int k = 0; k < N_CH; k++) begin
            scan_idx = (int'(ptr) + k) % N_CH;
            if (!found && bus.req_valid_in[scan_idx]) begin
                found           = 1'b1;
                grant[scan_idx] = 1'b1;
                grant_idx       = CH_W'(scan_idx);
            end
        end
    end

    assign bus.req_ready_out = (rst_n_in && adv) ? grant : '0;
    assign xfer              = found && adv && rst_n_in;

    assign a_sel = bus.a_in[int'(grant_idx)*WIDTH +: WIDTH];
    assign b_sel = bus.b_in[int'(grant_idx)*WIDTH +: WIDTH];

`ifdef SHARED_MUL_SIGNED_EN
    assign a_ext = {{WIDTH{a_sel[WIDTH-1]}}, a_sel};
    assign b_ext = {{WIDTH{b_sel[WIDTH-1]}}, b_sel};
`else
    assign a_ext = {{WIDTH{1'b0}}, a_sel};
    assign b_ext = {{WIDTH{1'b0}}, b_sel};
`endif

    // Low 2*WIDTH bits of the extended product are exact in both builds.
    assign prod = a_ext * b_ext;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ptr <= '0;
            for (int s = 0; s < PIPE; s++) begin
                vld_q[s]  <= 1'b0;
                prod_q[s] <= '0;
                ch_q[s]   <= '0;
            end
        end else if (adv) begin
            vld_q[0] <= xfer;
            if (xfer) begin
                prod_q[0] <= prod;
                ch_q[0]   <= grant_idx;
                ptr       <= (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + 1'b1;
            end
            for (int s = 1; s < PIPE; s++) begin
                vld_q[s]  <= vld_q[s-1];
                prod_q[s] <= prod_q[s-1];
                ch_q[s]   <= ch_q[s-1];
            end
        end
    end

    assign bus.res_valid_out = vld_q[PIPE-1];
    assign bus.res_out       = prod_q[PIPE-1];
    assign bus.res_ch_out    = ch_q[PIPE-1];
endmodule

// File: tb/tb_shared_mul_rr.sv
// Bench for shared_mul_rr: three instances (PIPE=2,1,4) share stimulus and are
// each tracked by a queue-based reference model; directed cases run on PIPE=2.
module tb_shared_mul_rr;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int ND = 3;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req_valid;
    logic [N*W-1:0] a_bus;
    logic [N*W-1:0] b_bus;
    logic         res_ready;

    int n_checks = 0;
    int n_fail   = 0;

    shared_mul_rr_if #(.N_CH(N), .WIDTH(W)) bus_p2 ();
    shared_mul_rr_if #(.N_CH(N), .WIDTH(W)) bus_p1 ();
    shared_mul_rr_if #(.N_CH(N), .WIDTH(W)) bus_p4 ();

    assign bus_p2.req_valid_in = req_valid;
    assign bus_p2.a_in         = a_bus;
    assign bus_p2.b_in         = b_bus;
    assign bus_p2.res_ready_in = res_ready;
    assign bus_p1.req_valid_in = req_valid;
    assign bus_p1.a_in         = a_bus;
    assign bus_p1.b_in         = b_bus;
    assign bus_p1.res_ready_in = res_ready;
    assign bus_p4.req_valid_in = req_valid;
    assign bus_p4.a_in         = a_bus;
    assign bus_p4.b_in         = b_bus;
    assign bus_p4.res_ready_in = res_ready;

    shared_mul_rr #(.N_CH(N), .WIDTH(W), .PIPE(2)) u_dut_p2 (.clk_in(clk), .rst_n_in(rst_n), .bus(bus_p2));
    shared_mul_rr #(.N_CH(N), .WIDTH(W), .PIPE(1)) u_dut_p1 (.clk_in(clk), .rst_n_in(rst_n), .bus(bus_p1));
    shared_mul_rr #(.N_CH(N), .WIDTH(W), .PIPE(4)) u_dut_p4 (.clk_in(clk), .rst_n_in(rst_n), .bus(bus_p4));

    logic [N-1:0]   rdy_o [ND];
    logic           vld_o [ND];
    logic [2*W-1:0] res_o [ND];
    logic [1:0]     ch_o  [ND];

    assign rdy_o[0] = bus_p2.req_ready_out;
    assign vld_o[0] = bus_p2.res_valid_out;
    assign res_o[0] = bus_p2.res_out;
    assign ch_o[0]  = bus_p2.res_ch_out;
    assign rdy_o[1] = bus_p1.req_ready_out;
    assign vld_o[1] = bus_p1.res_valid_out;
    assign res_o[1] = bus_p1.res_out;
    assign ch_o[1]  = bus_p1.res_ch_out;
    assign rdy_o[2] = bus_p4.req_ready_out;
    assign vld_o[2] = bus_p4.res_valid_out;
    assign res_o[2] = bus_p4.res_out;
    assign ch_o[2]  = bus_p4.res_ch_out;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pipe_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [15:0] mul_ref(input logic [7:0] a, input logic [7:0] b);
        int p;
`ifdef SHARED_MUL_SIGNED_EN
        p = int'($signed(a)) * int'($signed(b));
`else
        p = int'(a) * int'(b);
`endif
        return 16'(p);
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        int idx;
        idx = -1;
        for (int i = 0; i < N; i++)
            if (v[i]) idx = (idx < 0) ? i : -2;
        return idx;
    endfunction

    // Reference model: a product becomes visible once PIPE-1 further advancing
    // edges have passed since its acceptance; results leave strictly in order.
    typedef struct {
        logic [15:0] prod;
        int          ch;
        longint      stamp;
    } item_t;

    item_t  mq      [ND][$];
    int     ptr_m   [ND];
    longint adv_cnt [ND];

    task automatic model_step(input int d);
        logic         exp_v;
        logic         adv;
        int           g;
        logic [N-1:0] exp_rdy;
        item_t        it;
        if (!rst_n) begin
            chk($sformatf("d%0d_rst_ready", d), 32'(rdy_o[d]), 0);
            chk($sformatf("d%0d_rst_valid", d), 32'(vld_o[d]), 0);
            chk($sformatf("d%0d_rst_res", d), 32'(res_o[d]), 0);
            chk($sformatf("d%0d_rst_ch", d), 32'(ch_o[d]), 0);
            mq[d].delete();
            ptr_m[d]   = 0;
            adv_cnt[d] = 0;
            return;
        end
        exp_v = (mq[d].size() > 0) && (adv_cnt[d] - mq[d][0].stamp == longint'(pipe_of(d) - 1));
        adv   = !exp_v || res_ready;
        g     = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr_m[d] + k) % N;
            if (g < 0 && req_valid[c]) g = c;
        end
        exp_rdy = (g >= 0 && adv) ? (4'b0001 << g) : 4'b0000;
        chk($sformatf("d%0d_req_ready", d), 32'(rdy_o[d]), 32'(exp_rdy));
        chk($sformatf("d%0d_res_valid", d), 32'(vld_o[d]), 32'(exp_v));
        if (exp_v) begin
            chk($sformatf("d%0d_res_out", d), 32'(res_o[d]), 32'(mq[d][0].prod));
            chk($sformatf("d%0d_res_ch", d), 32'(ch_o[d]), 32'(mq[d][0].ch));
        end
        if (exp_v && res_ready) void'(mq[d].pop_front());
        if (adv) adv_cnt[d]++;
        if (g >= 0 && adv) begin
            it.prod  = mul_ref(a_bus[g*W +: W], b_bus[g*W +: W]);
            it.ch    = g;
            it.stamp = adv_cnt[d];
            mq[d].push_back(it);
            ptr_m[d] = (g + 1) % N;
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) model_step(d);
    end

    typedef struct {
        int          ch;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_u;
        logic [15:0] exp_s;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int acc;
        int rr_exp [6];
        logic [15:0] exp_p;

        vecs[0] = '{2, 8'd3,   8'd5,   16'd15,    16'd15};
        vecs[1] = '{0, 8'd255, 8'd255, 16'd65025, 16'd1};
        vecs[2] = '{1, 8'd253, 8'd5,   16'd1265,  16'hFFF1};
        vecs[3] = '{3, 8'd0,   8'd200, 16'd0,     16'd0};
        vecs[4] = '{0, 8'd128, 8'd2,   16'd256,   16'hFF00};
        vecs[5] = '{3, 8'd255, 8'd1,   16'd255,   16'hFFFF};
        vecs[6] = '{1, 8'd127, 8'd127, 16'd16129, 16'd16129};
        rr_exp  = '{0, 1, 2, 3, 0, 1};

        rst_n     = 1'b1;
        req_valid = '0;
        a_bus     = '0;
        b_bus     = '0;
        res_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single requests: one-cycle result pulse PIPE cycles after acceptance.
        for (int v = 0; v < 7; v++) begin
`ifdef SHARED_MUL_SIGNED_EN
            exp_p = vecs[v].exp_s;
`else
            exp_p = vecs[v].exp_u;
`endif
            a_bus = '0;
            b_bus = '0;
            a_bus[vecs[v].ch*W +: W] = vecs[v].a;
            b_bus[vecs[v].ch*W +: W] = vecs[v].b;
            req_valid = 4'b0001 << vecs[v].ch;
            @(negedge clk);
            chk("vec_ready", 32'(rdy_o[0]), 32'(4'b0001 << vecs[v].ch));
            tick();
            req_valid = '0;
            lat = 1;
            @(negedge clk);
            while (!vld_o[0] && lat < 10) begin
                tick();
                lat++;
                @(negedge clk);
            end
            chk("vec_latency", 32'(lat), 2);
            chk("vec_res", 32'(res_o[0]), 32'(exp_p));
            chk("vec_ch", 32'(ch_o[0]), 32'(vecs[v].ch));
            tick();
            @(negedge clk);
            chk("vec_single_pulse", 32'(vld_o[0]), 0);
            tick();
        end

        // Round-robin from a fresh pointer with every channel requesting.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < N; c++) begin
            a_bus[c*W +: W] = 8'(c + 1);
            b_bus[c*W +: W] = 8'(10 + c);
        end
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            acc = onehot_idx(rdy_o[0]);
            chk($sformatf("rr_order_%0d", k), 32'(acc), 32'(rr_exp[k]));
            tick();
        end

        // Stall: ch0's product (1*10) is at the output, ch1's (2*11) behind it.
        res_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("bp_ready_zero", 32'(rdy_o[0]), 0);
            chk("bp_valid", 32'(vld_o[0]), 1);
            chk("bp_res_frozen", 32'(res_o[0]), 10);
            chk("bp_ch_frozen", 32'(ch_o[0]), 0);
            tick();
        end
        res_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("drain0_valid", 32'(vld_o[0]), 1);
        chk("drain0_ch", 32'(ch_o[0]), 0);
        tick();
        @(negedge clk);
        chk("drain1_valid", 32'(vld_o[0]), 1);
        chk("drain1_res", 32'(res_o[0]), 22);
        chk("drain1_ch", 32'(ch_o[0]), 1);
        tick();
        @(negedge clk);
        chk("drain2_empty", 32'(vld_o[0]), 0);
        tick();
        repeat (3) tick();

        // Reset with two products in flight; pointer is left away from 0.
        a_bus = '0;
        b_bus = '0;
        a_bus[1*W +: W] = 8'd7;
        b_bus[1*W +: W] = 8'd9;
        a_bus[2*W +: W] = 8'd11;
        b_bus[2*W +: W] = 8'd13;
        a_bus[3*W +: W] = 8'd2;
        b_bus[3*W +: W] = 8'd3;
        req_valid = 4'b0110;
        tick();
        tick();
        req_valid = 4'b1010;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(vld_o[0]), 0);
        chk("mid_rst_res", 32'(res_o[0]), 0);
        chk("mid_rst_ch", 32'(ch_o[0]), 0);
        chk("mid_rst_ready", 32'(rdy_o[0]), 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", 32'(rdy_o[0]), 32'(4'b0010));
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("post_rst_no_stale", 32'(vld_o[0]), 0);
        tick();
        @(negedge clk);
        chk("post_rst_valid", 32'(vld_o[0]), 1);
        chk("post_rst_res", 32'(res_o[0]), 63);
        chk("post_rst_ch", 32'(ch_o[0]), 1);
        tick();

        // Random traffic with random backpressure on all three depths.
        for (int i = 0; i < 3000; i++) begin
            req_valid = 4'($urandom);
            a_bus     = $urandom;
            b_bus     = $urandom;
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
